golden_nonce_tx: RTL and testbench
==================================

# golden_nonce_tx

Buffers golden nonces from the hash core and sends them to the host over a UART 8N1 serial line. It sits directly downstream of the hash core. It captures each one-cycle `golden_nonce_match` strobe together with the 32-bit `golden_nonce_out` value into a small FIFO. Each buffered nonce is then serialized as four bytes, least-significant byte first, on `txd`. Matches are never lost silently: when the FIFO is full, the nonce is dropped and a sticky overflow flag is raised.

## Interface
- `BAUD_DIV`, default 868: hash_clk cycles per UART bit (100 MHz / 115200). Must be >= 2.
- `FIFO_DEPTH`, default 4: nonce entries in the FIFO. Must be a power of 2, >= 2.
- `hash_clk`  in  1: the only clock; everything is on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `golden_nonce_match`  in  1: one-cycle strobe; `golden_nonce` is valid in the same cycle.
- `golden_nonce`  in  32: nonce to transmit.
- `txd`  out  1: UART transmit line; idles high.
- `busy`  out  1: high while a word is being shifted or the FIFO is non-empty.
- `overflow`  out  1: sticky; set when a strobe arrives and cannot be stored.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: number of FIFO entries occupied.

## Operation
- **FIFO write.** On an edge where `golden_nonce_match`=1 and the FIFO is not full (after accounting for a same-cycle pop), `golden_nonce` is written at the write pointer. The pointer wraps modulo FIFO_DEPTH.
- **Full FIFO.** A strobe with the FIFO full and no same-cycle pop is dropped. `overflow` goes to 1 and stays there until reset.
- **Pop.** The FIFO is popped when the FSM is in IDLE and `fifo_count`>0. The head entry is loaded into a 32-bit shift word, the byte index is set to 0, and the FSM moves to START.
- **Push and pop together.** A same-cycle push and pop is always legal, including at full: `fifo_count` stays unchanged and both the head and the new entry are correct.
- **FSM states.**
  - IDLE: `txd`=1.
  - START: `txd`=0 for one bit time.
  - DATA: 8 bits of the current byte, LSB first.
  - STOP: `txd`=1 for one bit time.
- **Transitions.** After STOP, if the byte index is < 3, the index increments and the FSM goes to START with no idle gap. If the index is 3, the FSM goes to IDLE.
- **Byte order.** Byte k is `shift_word[8k+7:8k]`, so byte 0 is bits [7:0].
- **Bit timer.** The bit timer counts BAUD_DIV-1 down to 0. A state or bit advances on the edge where the timer is 0, and the timer reloads at that edge. A pop also reloads the timer to BAUD_DIV-1.
- **Bit counter.** A 3-bit counter selects the data bit; it wraps from 7 to 0 when the FSM enters STOP.
- **Outputs.** `busy` = (state != IDLE) | (`fifo_count` != 0), registered.
- **Reset.** Asserting `reset_n`=0 at any time, including mid-byte, immediately forces:
  - `txd`=1, `busy`=0, `overflow`=0, `fifo_count`=0
  - FSM to IDLE, both FIFO pointers to 0
  - the partial word is discarded.
- **Strobe during reset.** Strobes while `reset_n`=0 are ignored.

## Timing
- **Strobe to start bit.** A strobe sampled at edge N with the FSM idle and the FIFO empty gives:
  - `fifo_count`=1 after edge N
  - pop at edge N+1, with `txd`=0 from N+1.
- **Word length.** One word occupies exactly 40*BAUD_DIV cycles from the start-bit edge to the end of the last stop bit.
- **Next word.** With the FIFO non-empty, the next start bit begins one cycle after the FSM returns to IDLE. The inter-word gap is exactly 1 cycle of idle high.
- **Capacity.** Worst-case capacity before overflow is FIFO_DEPTH stored words plus 1 word in flight.
- **Output registration.** All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Single word.** BAUD_DIV=4; strobe `golden_nonce`=32'hDEADBEEF once.
  - `txd` carries bytes EF, BE, AD, DE, each framed as 0, 8 data bits LSB first, 1.
  - 4 cycles per bit, 160 cycles total; `busy` falls after the last stop bit.
- **Latency and idle.** After reset with no strobes, `txd` stays 1 and `busy` stays 0.
  - A strobe at edge N gives `txd`=0 at edge N+1, and `fifo_count` reads 1 then 0.
- **Burst to overflow.** BAUD_DIV=4 and FIFO_DEPTH=4; send 6 strobes on consecutive cycles with values 1..6.
  - Nonces 1..5 are transmitted in order, and 6 is dropped.
  - `overflow`=1 from the 6th strobe edge onward; `fifo_count` peaks at 4.
- **Push and pop at full.** Hold the FIFO full at the cycle the FSM pops, and strobe 32'h12345678 in that same cycle.
  - `fifo_count` stays 4, `overflow` stays 0, and 32'h12345678 is transmitted last.
- **Reset mid-operation.** Assert `reset_n`=0 mid-DATA of byte 2.
  - `txd`=1 immediately, with no clock edge needed; all outputs return to reset values.
  - After release, a new strobe of 32'h00000001 transmits cleanly.
- **Back-to-back words.** Send 2 words back to back; the stop bit of word 1 is followed by exactly 1 idle cycle, then the start bit of word 2.

Source files
------------

// File: rtl/golden_nonce_tx.sv
// golden_nonce_tx
//
// Buffers golden nonces reported by the hash core and sends each one to the
// host as four UART 8N1 bytes, least-significant byte first. Each
// golden_nonce_match strobe is captured into a small FIFO. A strobe that
// finds the FIFO full, with no pop in the same cycle, is dropped and raises
// the sticky overflow flag.
//
// Parameters
//   BAUD_DIV   hash_clk cycles per UART bit (>= 2)
//   FIFO_DEPTH nonce entries buffered (power of 2, >= 2)
//
// Ports
//   hash_clk            in   clock, rising edge
//   reset_n             in   asynchronous active-low reset
//   golden_nonce_match  in   one-cycle strobe qualifying golden_nonce
//   golden_nonce        in   32-bit nonce to transmit
//   txd                 out  UART transmit line, idles high (registered)
//   busy                out  word in flight or FIFO non-empty (registered)
//   overflow            out  sticky, a strobe was dropped (registered)
//   fifo_count          out  occupied FIFO entries (registered)
module golden_nonce_tx #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          hash_clk,
  input  logic                          reset_n,
  input  logic                          golden_nonce_match,
  input  logic [31:0]                   golden_nonce,
  output logic                          txd,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(BAUD_DIV);

  localparam logic [TW-1:0] TMR_LOAD = TW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [1:0]      byte_idx, byte_idx_nxt;
  logic [31:0]     shift_word, shift_word_nxt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic            txd_nxt, busy_nxt, overflow_nxt;
  logic            tick, push, pop;

  logic [31:0]     mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    tmr_nxt        = tmr;
    bit_cnt_nxt    = bit_cnt;
    byte_idx_nxt   = byte_idx;
    shift_word_nxt = shift_word;
    pop            = 1'b0;
    push           = 1'b0;
    txd_nxt        = 1'b1;
    busy_nxt       = 1'b0;
    overflow_nxt   = overflow;
    count_nxt      = fifo_count;
    tick           = (tmr == '0);

    // The bit timer free-runs only while a word is on the line; it reloads
    // on the edge where it expires, which is also the edge that advances
    // the bit or state.
    if (state != IDLE) begin
      tmr_nxt = tick ? TMR_LOAD : tmr - TW'(1);
    end

    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop            = 1'b1;
          shift_word_nxt = mem[rd_ptr];
          byte_idx_nxt   = 2'd0;
          bit_cnt_nxt    = 3'd0;
          tmr_nxt        = TMR_LOAD;
          state_nxt      = START;
        end
      end
      START: begin
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        if (tick) begin
          // 3-bit counter wraps 7 -> 0 on the way into STOP, leaving it
          // ready for the next byte.
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (byte_idx == 2'd3) begin
            state_nxt = IDLE;
          end else begin
            byte_idx_nxt = byte_idx + 2'd1;
            state_nxt    = START;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A same-cycle pop frees a slot, so a push is accepted even at full.
    push         = golden_nonce_match && ((fifo_count != FULL_CNT) || pop);
    overflow_nxt = overflow | (golden_nonce_match & ~push);
    count_nxt    = fifo_count + CW'(push) - CW'(pop);

    // txd is registered: drive the level belonging to the state being
    // entered so the line changes on the same edge as the FSM.
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_word_nxt[{byte_idx_nxt, bit_cnt_nxt}];
      default: txd_nxt = 1'b1;
    endcase

    busy_nxt = (state_nxt != IDLE) || (count_nxt != '0);
  end

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tmr        <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      txd        <= 1'b1;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmr        <= tmr_nxt;
      bit_cnt    <= bit_cnt_nxt;
      byte_idx   <= byte_idx_nxt;
      fifo_count <= count_nxt;
      txd        <= txd_nxt;
      busy       <= busy_nxt;
      overflow   <= overflow_nxt;
      // Power-of-2 depth: pointers wrap by natural overflow.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Data registers (no reset; only read once the FSM has loaded them)
  // ---------------------------------------------------------------------
  always_ff @(posedge hash_clk) begin
    shift_word <= shift_word_nxt;
    // At full with a same-cycle pop, wr_ptr == rd_ptr: the head has already
    // been read combinationally above, so overwriting the slot is safe.
    if (push) mem[wr_ptr] <= golden_nonce;
  end

endmodule

// File: tb/tb_golden_nonce_tx.sv
module tb_golden_nonce_tx;

  localparam int BAUD_DIV   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = 3;
  localparam int WORD_CYC   = 40 * BAUD_DIV;

  logic          hash_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          golden_nonce_match = 1'b0;
  logic [31:0]   golden_nonce = '0;
  logic          txd;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  int n_chk   = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mon_err = 0;

  logic [31:0] rx_q[$];
  int          rx_t[$];

  int burst_cnt[6] = '{1, 1, 2, 3, 4, 4};
  int burst_ovf[6] = '{0, 0, 0, 0, 0, 1};
  logic [31:0] pp_words[6] = '{32'hA5A50001, 32'hA5A50002, 32'hA5A50003,
                               32'hA5A50004, 32'hA5A50005, 32'h12345678};

  golden_nonce_tx #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .hash_clk           (hash_clk),
    .reset_n            (reset_n),
    .golden_nonce_match (golden_nonce_match),
    .golden_nonce       (golden_nonce),
    .txd                (txd),
    .busy               (busy),
    .overflow           (overflow),
    .fifo_count         (fifo_count)
  );

  always #5 hash_clk = ~hash_clk;
  always @(posedge hash_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_words(input int n, input int limit, input string tag);
    int k;
    k = 0;
    while (rx_q.size() < n && k < limit) begin
      tick();
      k++;
    end
    chk(tag, rx_q.size(), n);
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 'x;
  endfunction

  function automatic int t_at(input int i);
    if (i < rx_t.size()) return rx_t[i];
    return -1000000;
  endfunction

  task automatic chk_gaps(input string tag);
    int bad;
    bad = 0;
    for (int i = 1; i < rx_t.size(); i++)
      if (rx_t[i] - rx_t[i-1] != WORD_CYC + 1) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
  endtask

  // UART receiver: samples every cycle, checks each bit is stable for the
  // whole bit time, checks framing, and records start-edge cycle numbers.
  initial begin : monitor
    logic [31:0] w;
    int          t0;
    logic        first;
    logic        aborted;
    forever begin
      @(posedge hash_clk);
      #1;
      if (reset_n === 1'b1 && txd === 1'b0) begin
        t0      = cyc;
        w       = '0;
        aborted = 1'b0;
        first   = 1'b0;
        for (int b = 0; b < 40 && !aborted; b++) begin
          for (int c = 0; c < BAUD_DIV && !aborted; c++) begin
            if (b != 0 || c != 0) begin
              @(posedge hash_clk);
              #1;
            end
            if (reset_n !== 1'b1) begin
              aborted = 1'b1;
            end else begin
              if (c == 0) first = txd;
              else if (txd !== first) mon_err++;
              if (c == BAUD_DIV / 2) begin
                if (b % 10 == 0) begin
                  if (txd !== 1'b0) mon_err++;
                end else if (b % 10 == 9) begin
                  if (txd !== 1'b1) mon_err++;
                end else begin
                  w[8*(b/10) + (b%10) - 1] = txd;
                end
              end
            end
          end
        end
        if (!aborted) begin
          rx_q.push_back(w);
          rx_t.push_back(t0);
        end
      end
    end
  end

  initial begin : stim
    int t_start;
    int bad;

    // Reset state and quiet idle
    reset_n = 1'b0;
    ticks(3);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fifo_count", fifo_count, 0);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_count !== '0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Single word, latency and word length
    golden_nonce = 32'hDEADBEEF;
    golden_nonce_match = 1'b1;
    tick();
    golden_nonce_match = 1'b0;
    chk("lat_fifo_count", fifo_count, 1);
    chk("lat_busy", busy, 1);
    chk("lat_txd_still_idle", txd, 1);
    tick();
    chk("lat_start_bit", txd, 0);
    chk("lat_fifo_popped", fifo_count, 0);
    t_start = cyc;
    ticks(WORD_CYC - 1);
    chk("last_stop_txd", txd, 1);
    chk("last_stop_busy", busy, 1);
    tick();
    chk("busy_fall", busy, 0);
    chk("end_txd", txd, 1);
    ticks(2);
    chk("single_words", rx_q.size(), 1);
    chk("single_word_value", q_at(0), 32'hDEADBEEF);
    chk("single_start_cycle", t_at(0), t_start);

    // Burst of 6 strobes into a 4-deep FIFO
    clear_rx();
    ticks(3);
    for (int i = 1; i <= 6; i++) begin
      golden_nonce = 32'(i);
      golden_nonce_match = 1'b1;
      tick();
      chk($sformatf("burst_count_%0d", i), fifo_count, burst_cnt[i-1]);
      chk($sformatf("burst_ovf_%0d", i), overflow, burst_ovf[i-1]);
    end
    golden_nonce_match = 1'b0;
    wait_words(5, 5 * (WORD_CYC + 1) + 20, "burst_words");
    ticks(WORD_CYC + 20);
    chk("burst_sixth_dropped", rx_q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("burst_word_%0d", i), q_at(i), 32'(i + 1));
    chk_gaps("burst_gaps");
    chk("burst_ovf_sticky", overflow, 1);
    chk("burst_busy_done", busy, 0);

    // Reset in the middle of byte 2's data bits
    clear_rx();
    ticks(2);
    golden_nonce = 32'hCAFEF00D;
    golden_nonce_match = 1'b1;
    tick();
    golden_nonce_match = 1'b0;
    tick();
    chk("mid_start_bit", txd, 0);
    ticks(85);
    chk("pre_rst_txd_b2_bit0", txd, 0);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_overflow", overflow, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_txd", txd, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_overflow", overflow, 0);
    chk("async_rst_fifo_count", fifo_count, 0);
    golden_nonce = 32'h00000055;
    golden_nonce_match = 1'b1;
    tick();
    tick();
    golden_nonce_match = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("post_rst_fifo_count", fifo_count, 0);
    chk("post_rst_txd", txd, 1);
    chk("post_rst_busy", busy, 0);
    ticks(5);
    chk("aborted_word_not_received", rx_q.size(), 0);
    golden_nonce = 32'h00000001;
    golden_nonce_match = 1'b1;
    tick();
    golden_nonce_match = 1'b0;
    wait_words(1, WORD_CYC + 20, "post_rst_words");
    chk("post_rst_word_value", q_at(0), 32'h00000001);

    // Push and pop in the same cycle with the FIFO full
    clear_rx();
    ticks(3);
    golden_nonce_match = 1'b1;
    for (int i = 0; i < 5; i++) begin
      golden_nonce = pp_words[i];
      tick();
    end
    golden_nonce_match = 1'b0;
    chk("pp_full_count", fifo_count, 4);
    ticks(WORD_CYC - 4);
    chk("pp_pre_stop_txd", txd, 1);
    chk("pp_pre_count", fifo_count, 4);
    tick();
    chk("pp_idle_gap_txd", txd, 1);
    chk("pp_idle_count", fifo_count, 4);
    golden_nonce = pp_words[5];
    golden_nonce_match = 1'b1;
    tick();
    golden_nonce_match = 1'b0;
    chk("pp_count_held", fifo_count, 4);
    chk("pp_overflow_clear", overflow, 0);
    chk("pp_start_bit", txd, 0);
    wait_words(6, 6 * (WORD_CYC + 1) + 20, "pp_words");
    ticks(WORD_CYC);
    chk("pp_total_words", rx_q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("pp_word_%0d", i), q_at(i), pp_words[i]);
    chk_gaps("pp_gaps");
    chk("pp_overflow_final", overflow, 0);

    // Two words back to back
    clear_rx();
    ticks(3);
    golden_nonce_match = 1'b1;
    golden_nonce = 32'h0F0F0F0F;
    tick();
    golden_nonce = 32'hF0F0F0F0;
    tick();
    golden_nonce_match = 1'b0;
    wait_words(2, 2 * (WORD_CYC + 1) + 20, "b2b_words");
    chk("b2b_word0", q_at(0), 32'h0F0F0F0F);
    chk("b2b_word1", q_at(1), 32'hF0F0F0F0);
    chk("b2b_gap", t_at(1) - t_at(0), WORD_CYC + 1);

    ticks(5);
    chk("uart_framing_errors", mon_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
